// File: rtl/blood_fx_if.sv
`default_nettype none
// ============================================================================
//  Module      : blood_fx_if
//  Description : Hit-request handshake between the two fighters and the
//                blood splatter sequencer.
//                hit_req  - level request per player (bit0 = player 0)
//                hit_x0/y0, hit_x1/y1 - requested sprite top-left origin
//                hit_ack  - one-cycle grant pulse per player
//                master   : fighter side (drives requests, sees acks)
//                slave    : sequencer side
//  Revision    : 1.0 - initial release
// ============================================================================
interface blood_fx_if;
    logic [1:0] hit_req;
    logic [9:0] hit_x0;
    logic [9:0] hit_y0;
    logic [9:0] hit_x1;
    logic [9:0] hit_y1;
    logic [1:0] hit_ack;

    modport master (
        output hit_req, hit_x0, hit_y0, hit_x1, hit_y1,
        input  hit_ack
    );

    modport slave (
        input  hit_req, hit_x0, hit_y0, hit_x1, hit_y1,
        output hit_ack
    );
endinterface
`default_nettype wire

// File: rtl/blood_fx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : blood_fx_sequencer
//  Description : Shared 64x64 blood-splatter animation sequencer. Arbitrates
//                hit requests from two players (round-robin on collisions),
//                latches a clamped sprite origin, steps frame ROMs on vblank
//                and produces a pixel-aligned colour/enable pair.
//  Ports       : clk, reset_n     - clock, async active-low reset
//                frame_tick       - one-cycle pulse at vblank start
//                video_on, x, y   - current raster position
//                hit              - request/ack handshake (slave modport)
//                busy             - animation in progress (state != IDLE)
//                rom_frame/row/col- frame ROM select and address
//                rom_color        - ROM data, one cycle after the address
//                blood_on/rgb     - draw enable and colour to compositor
//  Revision    : 1.0 - initial release
// ============================================================================
module blood_fx_sequencer #(
    parameter int NUM_FRAMES = 22,
    parameter int FRAME_W    = 5,
    parameter int FRAME_HOLD = 3,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               frame_tick,
    input  wire logic               video_on,
    input  wire logic [9:0]         x,
    input  wire logic [9:0]         y,
    blood_fx_if.slave               hit,
    output logic                    busy,
    output logic [FRAME_W-1:0]      rom_frame,
    output logic [5:0]              rom_row,
    output logic [5:0]              rom_col,
    input  wire logic [11:0]        rom_color,
    output logic                    blood_on,
    output logic [11:0]             blood_rgb
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
    // Origins are clamped so the whole sprite stays on screen.
    localparam logic [9:0]         X_MAX      = 10'(H_RES - 64);
    localparam logic [9:0]         Y_MAX      = 10'(V_RES - 64);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [1:0]         hit_ack_q,    hit_ack_d;
    logic [FRAME_W-1:0] rom_frame_q,  rom_frame_d;
    logic [HOLD_W-1:0]  hold_cnt_q,   hold_cnt_d;
    logic [9:0]         ox_q,         ox_d;
    logic [9:0]         oy_q,         oy_d;
    logic               last_grant_q, last_grant_d;
    // Pipeline copies of in_box / video_on, aligned with ROM data.
    logic               in_box_q,     in_box_d;
    logic               video_on_q,   video_on_d;

    logic               grant;
    logic [9:0]         grant_x;
    logic [9:0]         grant_y;

    always_comb begin
        state_d      = state_q;
        hit_ack_d    = 2'b00;
        rom_frame_d  = rom_frame_q;
        hold_cnt_d   = hold_cnt_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        last_grant_d = last_grant_q;

        // Collision goes to whoever was not served last.
        grant   = (hit.hit_req == 2'b11) ? ~last_grant_q : hit.hit_req[1];
        grant_x = grant ? hit.hit_x1 : hit.hit_x0;
        grant_y = grant ? hit.hit_y1 : hit.hit_y0;

        case (state_q)
            IDLE: begin
                // frame_tick is deliberately not looked at here, so a tick
                // in the grant cycle cannot start the animation early.
                if (hit.hit_req != 2'b00) begin
                    hit_ack_d    = grant ? 2'b10 : 2'b01;
                    last_grant_d = grant;
                    ox_d         = (grant_x > X_MAX) ? X_MAX : grant_x;
                    oy_d         = (grant_y > Y_MAX) ? Y_MAX : grant_y;
                    state_d      = ARM;
                end
            end
            ARM: begin
                if (frame_tick) begin
                    rom_frame_d = '0;
                    hold_cnt_d  = '0;
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (hold_cnt_q < HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end else begin
                        hold_cnt_d = '0;
                        if (rom_frame_q == LAST_FRAME) begin
                            rom_frame_d = '0;
                            state_d     = IDLE;
                        end else begin
                            rom_frame_d = rom_frame_q + FRAME_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Box test in 11 bits so ox+64 cannot wrap.
    logic [10:0] x_ext, y_ext, ox_ext, oy_ext;
    logic        in_box;

    always_comb begin
        x_ext  = {1'b0, x};
        y_ext  = {1'b0, y};
        ox_ext = {1'b0, ox_q};
        oy_ext = {1'b0, oy_q};
        in_box = (state_q == PLAY) &&
                 (x_ext >= ox_ext) && (x_ext < ox_ext + 11'd64) &&
                 (y_ext >= oy_ext) && (y_ext < oy_ext + 11'd64);
        in_box_d   = in_box;
        video_on_d = video_on;
        // Low six bits of the difference only depend on the low six bits.
        rom_col = in_box ? (x[5:0] - ox_q[5:0]) : 6'd0;
        rom_row = in_box ? (y[5:0] - oy_q[5:0]) : 6'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hit_ack_q    <= 2'b00;
            rom_frame_q  <= '0;
            hold_cnt_q   <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            last_grant_q <= 1'b1;
            in_box_q     <= 1'b0;
            video_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_ack_q    <= hit_ack_d;
            rom_frame_q  <= rom_frame_d;
            hold_cnt_q   <= hold_cnt_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            last_grant_q <= last_grant_d;
            in_box_q     <= in_box_d;
            video_on_q   <= video_on_d;
        end
    end

    assign hit.hit_ack = hit_ack_q;
    assign busy        = (state_q != IDLE);
    assign rom_frame   = rom_frame_q;
    // Black pixels are transparent.
    assign blood_on    = in_box_q & video_on_q & (rom_color != 12'h000);
    assign blood_rgb   = blood_on ? rom_color : 12'h000;

endmodule
`default_nettype wire
